// File: rtl/trap_ctrl_pkg.sv
// Shared types and constants for the machine-mode trap/return sequencer.
// Holds exception cause codes, the owned CSR addresses and the sequencer state encoding.
package trap_ctrl_pkg;

    typedef enum logic [3:0] {
        EX_INSTR_MISALIGN = 4'd0,
        EX_INSTR_FAULT    = 4'd1,
        EX_ILLEGAL_INSTR  = 4'd2,
        EX_BREAKPOINT     = 4'd3,
        EX_LOAD_MISALIGN  = 4'd4,
        EX_LOAD_FAULT     = 4'd5,
        EX_STORE_MISALIGN = 4'd6,
        EX_STORE_FAULT    = 4'd7,
        EX_U_ECALL        = 4'd8,
        EX_S_ECALL        = 4'd9,
        EX_M_ECALL        = 4'd11
    } ex_type;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;

    typedef enum logic [1:0] {
        TS_IDLE     = 2'd0,
        TS_FLUSH    = 2'd1,
        TS_REDIRECT = 2'd2
    } trap_state_t;

    localparam int MSTATUS_MIE_BIT  = 3;
    localparam int MSTATUS_MPIE_BIT = 7;

endpackage

// File: rtl/trap_ctrl_csr_file.sv
// Machine trap CSR storage: software read/write port plus trap/MRET hardware updates.
// A hardware update of a register in the same cycle as a software write to it wins.
module trap_csr_file
    import trap_ctrl_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_MTVEC = 32'h8000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            trap_we,
    input  logic            mret_we,
    input  logic [XLEN-1:0] trap_pc,
    input  ex_type          trap_cause,
    input  logic [XLEN-1:0] trap_tval,
    input  logic [11:0]     csr_addr,
    input  logic            csr_we,
    input  logic [XLEN-1:0] csr_wdata,
    output logic [XLEN-1:0] csr_rdata,
    output logic            csr_hit,
    output logic            mie,
    output logic [XLEN-1:0] mtvec,
    output logic [XLEN-1:0] mepc
);

    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    logic [XLEN-1:0] mcause;
    logic [XLEN-1:0] mtval;
    logic            mpie;

    logic sw_mstatus;
    logic sw_mtvec;
    logic sw_mepc;
    logic sw_mcause;
    logic sw_mtval;

    assign sw_mstatus = csr_we && (csr_addr == CSR_MSTATUS);
    assign sw_mtvec   = csr_we && (csr_addr == CSR_MTVEC);
    assign sw_mepc    = csr_we && (csr_addr == CSR_MEPC);
    assign sw_mcause  = csr_we && (csr_addr == CSR_MCAUSE);
    assign sw_mtval   = csr_we && (csr_addr == CSR_MTVAL);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mie    <= 1'b0;
            mpie   <= 1'b0;
            mtvec  <= RESET_MTVEC & ALIGN_MASK;
            mepc   <= '0;
            mcause <= '0;
            mtval  <= '0;
        end else begin
            // NOTE: non-blocking assignments let mpie sample the old mie in the same edge.
            if (trap_we) begin
                mpie <= mie;
                mie  <= 1'b0;
            end else if (mret_we) begin
                mie  <= mpie;
                mpie <= 1'b1;
            end else if (sw_mstatus) begin
                mie  <= csr_wdata[MSTATUS_MIE_BIT];
                mpie <= csr_wdata[MSTATUS_MPIE_BIT];
            end

            if (trap_we) begin
                mepc   <= trap_pc & ALIGN_MASK;
                mcause <= XLEN'(trap_cause);
                mtval  <= trap_tval;
            end else begin
                if (sw_mepc)   mepc   <= csr_wdata & ALIGN_MASK;
                if (sw_mcause) mcause <= csr_wdata;
                if (sw_mtval)  mtval  <= csr_wdata;
            end

            if (sw_mtvec) mtvec <= csr_wdata & ALIGN_MASK;
        end
    end

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        csr_rdata = '0;
        csr_hit   = 1'b1;
        case (csr_addr)
            CSR_MSTATUS: begin
                csr_rdata[MSTATUS_MIE_BIT]  = mie;
                csr_rdata[MSTATUS_MPIE_BIT] = mpie;
            end
            CSR_MTVEC:  csr_rdata = mtvec;
            CSR_MEPC:   csr_rdata = mepc;
            CSR_MCAUSE: csr_rdata = mcause;
            CSR_MTVAL:  csr_rdata = mtval;
            default:    csr_hit   = 1'b0;
        endcase
    end

endmodule

// File: rtl/trap_ctrl.sv
// Trap/return sequencer: records traps and MRETs into the CSRs, then flushes the
// pipeline and offers a redirect to mtvec (trap) or mepc (MRET) to fetch.
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_MTVEC = 32'h8000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_ex_valid,
    input  ex_type          in_ex,
    input  logic            in_ret_valid,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_tval,
    output logic            flush,
    input  logic            drain_done,
    output logic            redir_valid,
    output logic [XLEN-1:0] redir_target,
    input  logic            redir_ready,
    input  logic [11:0]     csr_addr,
    input  logic            csr_we,
    input  logic [XLEN-1:0] csr_wdata,
    output logic [XLEN-1:0] csr_rdata,
    output logic            csr_hit,
    output logic            mie_out
);

    trap_state_t     state;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] mtvec;
    logic [XLEN-1:0] mepc;
    logic            accept;
    logic            take_trap;
    logic            take_mret;

    // in_ready is a registered copy of (state == TS_IDLE), so it gates accepts directly.
    assign accept    = in_valid && in_ready;
    assign take_trap = accept && in_ex_valid;
    assign take_mret = accept && !in_ex_valid && in_ret_valid;

    trap_csr_file #(
        .XLEN        (XLEN),
        .RESET_MTVEC (RESET_MTVEC)
    ) u_csr (
        .clk        (clk),
        .rst        (rst),
        .trap_we    (take_trap),
        .mret_we    (take_mret),
        .trap_pc    (in_pc),
        .trap_cause (in_ex),
        .trap_tval  (in_tval),
        .csr_addr   (csr_addr),
        .csr_we     (csr_we),
        .csr_wdata  (csr_wdata),
        .csr_rdata  (csr_rdata),
        .csr_hit    (csr_hit),
        .mie        (mie_out),
        .mtvec      (mtvec),
        .mepc       (mepc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= TS_IDLE;
            in_ready    <= 1'b1;
            flush       <= 1'b0;
            redir_valid <= 1'b0;
            target      <= '0;
        end else begin
            case (state)
                TS_IDLE: begin
                    // Target is frozen here so later CSR writes cannot move the redirect.
                    if (take_trap || take_mret) begin
                        target   <= take_trap ? mtvec : mepc;
                        state    <= TS_FLUSH;
                        in_ready <= 1'b0;
                        flush    <= 1'b1;
                    end
                end
                TS_FLUSH: begin
                    if (drain_done) begin
                        state       <= TS_REDIRECT;
                        flush       <= 1'b0;
                        redir_valid <= 1'b1;
                    end
                end
                TS_REDIRECT: begin
                    if (redir_ready) begin
                        state       <= TS_IDLE;
                        redir_valid <= 1'b0;
                        in_ready    <= 1'b1;
                    end
                end
                default: begin
                    state       <= TS_IDLE;
                    in_ready    <= 1'b1;
                    flush       <= 1'b0;
                    redir_valid <= 1'b0;
                end
            endcase
        end
    end

    assign redir_target = target;

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: table-driven trap/MRET vectors with a redirect
// scoreboard, plus hand-written reset, collision, back-pressure and async-reset cases.
module tb_trap_ctrl;
    import trap_ctrl_pkg::*;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic            in_ex_valid = 1'b0;
    ex_type          in_ex = EX_INSTR_MISALIGN;
    logic            in_ret_valid = 1'b0;
    logic [XLEN-1:0] in_pc = '0;
    logic [XLEN-1:0] in_tval = '0;
    logic            flush;
    logic            drain_done = 1'b0;
    logic            redir_valid;
    logic [XLEN-1:0] redir_target;
    logic            redir_ready = 1'b0;
    logic [11:0]     csr_addr = 12'h000;
    logic            csr_we = 1'b0;
    logic [XLEN-1:0] csr_wdata = '0;
    logic [XLEN-1:0] csr_rdata;
    logic            csr_hit;
    logic            mie_out;

    always #5 clk = ~clk;

    trap_ctrl #(
        .XLEN        (XLEN),
        .RESET_MTVEC (32'h8000_0000)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_ex_valid  (in_ex_valid),
        .in_ex        (in_ex),
        .in_ret_valid (in_ret_valid),
        .in_pc        (in_pc),
        .in_tval      (in_tval),
        .flush        (flush),
        .drain_done   (drain_done),
        .redir_valid  (redir_valid),
        .redir_target (redir_target),
        .redir_ready  (redir_ready),
        .csr_addr     (csr_addr),
        .csr_we       (csr_we),
        .csr_wdata    (csr_wdata),
        .csr_rdata    (csr_rdata),
        .csr_hit      (csr_hit),
        .mie_out      (mie_out)
    );

    int tests = 0;
    int fails = 0;
    logic [XLEN-1:0] exp_q[$];

    typedef struct {
        logic            ex_valid;
        logic            ret_valid;
        ex_type          ex;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] tval;
        int              drain_dly;
        int              ready_dly;
        logic            pre_wr;
        logic [XLEN-1:0] pre_mstatus;
        logic [XLEN-1:0] exp_mepc;
        logic [XLEN-1:0] exp_mcause;
        logic [XLEN-1:0] exp_mtval;
        logic [XLEN-1:0] exp_mstatus;
        logic [XLEN-1:0] exp_target;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic csr_write(input logic [11:0] addr, input logic [XLEN-1:0] data);
        @(negedge clk);
        csr_addr  = addr;
        csr_wdata = data;
        csr_we    = 1'b1;
        @(negedge clk);
        csr_we    = 1'b0;
    endtask

    task automatic csr_read(input logic [11:0] addr, output logic [XLEN-1:0] data);
        @(negedge clk);
        csr_addr = addr;
        #1;
        data = csr_rdata;
    endtask

    // One full accept -> flush -> redirect -> idle sequence with bounded waits.
    task automatic run_txn(input string tag, input logic ex_valid, input logic ret_valid,
                           input ex_type ex, input logic [XLEN-1:0] pc, input logic [XLEN-1:0] tval,
                           input logic [XLEN-1:0] exp_target, input int drain_dly, input int ready_dly,
                           input logic coll_mepc, input logic flush_mtvec_wr);
        int              cnt;
        logic [XLEN-1:0] tgt0;
        logic [XLEN-1:0] popped;
        @(negedge clk);
        check({tag, "_in_ready_idle"}, 32'(in_ready), 32'd1);
        in_valid     = 1'b1;
        in_ex_valid  = ex_valid;
        in_ret_valid = ret_valid;
        in_ex        = ex;
        in_pc        = pc;
        in_tval      = tval;
        if (coll_mepc) begin
            csr_addr  = CSR_MEPC;
            csr_wdata = 32'h5555_0004;
            csr_we    = 1'b1;
        end
        exp_q.push_back(exp_target);
        @(negedge clk);
        in_valid     = 1'b0;
        in_ex_valid  = 1'b0;
        in_ret_valid = 1'b0;
        csr_we       = 1'b0;

        cnt = 0;
        while (flush && cnt < 50) begin
            check({tag, "_in_ready_flush"}, 32'(in_ready), 32'd0);
            drain_done = (cnt >= drain_dly);
            if (flush_mtvec_wr && cnt == 0) begin
                csr_addr  = CSR_MTVEC;
                csr_wdata = 32'h9000_0000;
                csr_we    = 1'b1;
            end else begin
                csr_we = 1'b0;
            end
            @(negedge clk);
            cnt++;
        end
        drain_done = 1'b0;
        csr_we     = 1'b0;
        check({tag, "_flush_cycles"}, 32'(cnt), 32'(drain_dly + 1));

        cnt  = 0;
        tgt0 = redir_target;
        while (redir_valid && cnt < 50) begin
            check({tag, "_target_stable"}, redir_target, tgt0);
            check({tag, "_in_ready_redir"}, 32'(in_ready), 32'd0);
            redir_ready = (cnt >= ready_dly);
            @(negedge clk);
            cnt++;
        end
        redir_ready = 1'b0;
        check({tag, "_redir_cycles"}, 32'(cnt), 32'(ready_dly + 1));
        check({tag, "_in_ready_after"}, 32'(in_ready), 32'd1);
        check({tag, "_flush_after"}, 32'(flush), 32'd0);
        if (exp_q.size() > 0) begin
            popped = exp_q.pop_front();
            check({tag, "_redir_target"}, tgt0, popped);
        end else begin
            tests++;
            fails++;
            $display("FAIL %s_scoreboard: got redirect 0x%08h expected none queued", tag, tgt0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [XLEN-1:0] d;

        // mtvec = 0x8000_0040 throughout the table; mstatus starts at 0x08.
        vecs[0] = '{1'b1, 1'b0, EX_M_ECALL,        32'h8000_0104, 32'h0000_0000, 1, 0, 1'b0, 32'h0,
                    32'h8000_0104, 32'd11, 32'h0000_0000, 32'h80, 32'h8000_0040};
        vecs[1] = '{1'b0, 1'b1, EX_INSTR_MISALIGN, 32'h8000_0300, 32'hFFFF_FFFF, 0, 1, 1'b0, 32'h0,
                    32'h8000_0104, 32'd11, 32'h0000_0000, 32'h88, 32'h8000_0104};
        vecs[2] = '{1'b1, 1'b1, EX_ILLEGAL_INSTR,  32'h8000_0203, 32'hDEAD_BEEF, 0, 2, 1'b0, 32'h0,
                    32'h8000_0200, 32'd2,  32'hDEAD_BEEF, 32'h80, 32'h8000_0040};
        vecs[3] = '{1'b0, 1'b1, EX_INSTR_MISALIGN, 32'h0000_0010, 32'h0000_0000, 3, 0, 1'b0, 32'h0,
                    32'h8000_0200, 32'd2,  32'hDEAD_BEEF, 32'h88, 32'h8000_0200};
        vecs[4] = '{1'b1, 1'b0, EX_LOAD_FAULT,     32'h0000_1000, 32'h0000_1234, 2, 0, 1'b1, 32'h00,
                    32'h0000_1000, 32'd5,  32'h0000_1234, 32'h00, 32'h8000_0040};
        vecs[5] = '{1'b0, 1'b1, EX_INSTR_MISALIGN, 32'h0000_2000, 32'h0000_0000, 0, 0, 1'b1, 32'h08,
                    32'h0000_1000, 32'd5,  32'h0000_1234, 32'h80, 32'h0000_1000};

        repeat (3) @(negedge clk);
        rst = 1'b1;

        // Reset restores mtvec even after software changed it.
        csr_write(CSR_MTVEC, 32'h0000_1234);
        csr_read(CSR_MTVEC, d);
        check("mtvec_sw_write", d, 32'h0000_1234);
        csr_write(CSR_MSTATUS, 32'h0000_0088);
        @(negedge clk);
        rst = 1'b0;
        csr_read(CSR_MTVEC, d);
        check("rst_mtvec", d, 32'h8000_0000);
        csr_read(CSR_MSTATUS, d);
        check("rst_mstatus", d, 32'h0);
        csr_read(CSR_MEPC, d);
        check("rst_mepc", d, 32'h0);
        csr_read(CSR_MCAUSE, d);
        check("rst_mcause", d, 32'h0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_flush", 32'(flush), 32'd0);
        check("rst_redir_valid", 32'(redir_valid), 32'd0);
        check("rst_redir_target", redir_target, 32'h0);
        check("rst_mie_out", 32'(mie_out), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // CSR port: masking, alignment, hit decode.
        csr_write(CSR_MSTATUS, 32'hFFFF_FFFF);
        csr_read(CSR_MSTATUS, d);
        check("mstatus_mask", d, 32'h0000_0088);
        check("mie_out_set", 32'(mie_out), 32'd1);
        csr_write(CSR_MTVEC, 32'h8000_0043);
        csr_read(CSR_MTVEC, d);
        check("mtvec_align", d, 32'h8000_0040);
        csr_write(CSR_MEPC, 32'h0000_0107);
        csr_read(CSR_MEPC, d);
        check("mepc_align", d, 32'h0000_0104);
        csr_read(12'h344, d);
        check("unowned_rdata", d, 32'h0);
        check("unowned_hit", 32'(csr_hit), 32'd0);
        csr_read(CSR_MCAUSE, d);
        check("owned_hit", 32'(csr_hit), 32'd1);
        csr_write(CSR_MSTATUS, 32'h0000_0008);

        for (int i = 0; i < 6; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            if (vecs[i].pre_wr) csr_write(CSR_MSTATUS, vecs[i].pre_mstatus);
            run_txn(tag, vecs[i].ex_valid, vecs[i].ret_valid, vecs[i].ex, vecs[i].pc, vecs[i].tval,
                    vecs[i].exp_target, vecs[i].drain_dly, vecs[i].ready_dly, 1'b0, 1'b0);
            csr_read(CSR_MEPC, d);
            check({tag, "_mepc"}, d, vecs[i].exp_mepc);
            csr_read(CSR_MCAUSE, d);
            check({tag, "_mcause"}, d, vecs[i].exp_mcause);
            csr_read(CSR_MTVAL, d);
            check({tag, "_mtval"}, d, vecs[i].exp_mtval);
            csr_read(CSR_MSTATUS, d);
            check({tag, "_mstatus"}, d, vecs[i].exp_mstatus);
            check({tag, "_mie_out"}, 32'(mie_out), 32'(vecs[i].exp_mstatus[MSTATUS_MIE_BIT]));
        end

        // Accept with neither flag: nothing happens.
        @(negedge clk);
        in_valid = 1'b1;
        in_pc    = 32'h0000_5550;
        @(negedge clk);
        in_valid = 1'b0;
        check("plain_flush", 32'(flush), 32'd0);
        check("plain_in_ready", 32'(in_ready), 32'd1);
        check("plain_redir_valid", 32'(redir_valid), 32'd0);
        csr_read(CSR_MEPC, d);
        check("plain_mepc", d, 32'h0000_1000);
        csr_read(CSR_MSTATUS, d);
        check("plain_mstatus", d, 32'h0000_0080);

        // Collision: sw mepc write in accept cycle is dropped; mtvec write during FLUSH
        // lands in the CSR but not in the captured target; redirect held for 5 cycles.
        run_txn("coll", 1'b1, 1'b0, EX_BREAKPOINT, 32'h8000_0400, 32'h8000_0400,
                32'h8000_0040, 0, 5, 1'b1, 1'b1);
        csr_read(CSR_MEPC, d);
        check("coll_mepc_hw_wins", d, 32'h8000_0400);
        csr_read(CSR_MTVEC, d);
        check("coll_mtvec_written", d, 32'h9000_0000);
        csr_read(CSR_MCAUSE, d);
        check("coll_mcause", d, 32'd3);
        csr_read(CSR_MSTATUS, d);
        check("coll_mstatus", d, 32'h0000_0000);

        // Async reset while in REDIRECT: outputs drop with no clock edge.
        @(negedge clk);
        in_valid    = 1'b1;
        in_ex_valid = 1'b1;
        in_ex       = EX_M_ECALL;
        in_pc       = 32'h8000_0800;
        @(negedge clk);
        in_valid    = 1'b0;
        in_ex_valid = 1'b0;
        drain_done  = 1'b1;
        @(negedge clk);
        drain_done  = 1'b0;
        check("arst_pre_redir_valid", 32'(redir_valid), 32'd1);
        check("arst_pre_target", redir_target, 32'h9000_0000);
        #2;
        rst = 1'b0;
        #1;
        check("arst_redir_valid", 32'(redir_valid), 32'd0);
        check("arst_redir_target", redir_target, 32'h0);
        check("arst_in_ready", 32'(in_ready), 32'd1);
        check("arst_flush", 32'(flush), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("arst_post_in_ready", 32'(in_ready), 32'd1);
        check("arst_post_redir_valid", 32'(redir_valid), 32'd0);
        csr_read(CSR_MTVEC, d);
        check("arst_post_mtvec", d, 32'h8000_0000);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
